ddr3_port_arbiter: RTL
======================

// Module: ddr3_port_arbiter
// PURPOSE
//  Two-port round-robin arbiter sharing the single 128-bit request port of ddr3_core.
//  Serialises requests from two masters (e.g. CPU and DMA) onto the core inport.
//  Records the granted port index of every accepted request in a tag FIFO.
//  Uses that FIFO to route each in-order response (ack/error/resp_id/read_data) back to its issuer.
//  Sits between the masters and ddr3_core, in the clk_i domain of the core.
// PARAMETERS
//  OUTSTANDING  4  max accepted-but-unacknowledged requests (tag FIFO depth, power of 2, >=2)
// PORTS
//  clk_i               in   1    system clock; one clock, all logic on rising edge
//  rst_n_i             in   1    asynchronous active-low reset
//  p0_wr_i / p1_wr_i   in   16   per-port byte write strobes (non-zero = write)
//  p0_rd_i / p1_rd_i   in   1    per-port read request
//  pN_addr_i           in   32   request byte address
//  pN_write_data_i     in   128  write data
//  pN_req_id_i         in   16   requester tag, passed through unchanged
//  pN_accept_o         out  1    request accepted this cycle
//  pN_ack_o            out  1    response for this port valid this cycle
//  pN_error_o          out  1    response error (valid with pN_ack_o)
//  pN_resp_id_o        out  16   response tag (shared fan-out)
//  pN_read_data_o      out  128  read data (shared fan-out)
//  m_wr_o, m_rd_o, m_addr_o, m_write_data_o, m_req_id_o  out  16/1/32/128/16  to core inport
//  m_accept_i, m_ack_i, m_error_i, m_resp_id_i, m_read_data_i  in  1/1/1/16/128  from core
//  outstanding_o       in/out: out  clog2(OUTSTANDING)+1  current tag FIFO occupancy
//  unexpected_ack_o    out  1    sticky: m_ack_i seen with tag FIFO empty
// BEHAVIOUR
//  - Request valid on port N: req_N = |pN_wr_i | pN_rd_i. Masters hold the request stable until accepted.
//  - full = (occupancy == OUTSTANDING). While full, m_wr_o = 0 and m_rd_o = 0, and no accept is given.
//  - Select:
//      - if lock set, sel = locked port;
//      - else if exactly one req valid, sel = that port;
//      - else if both valid, sel = port other than last_grant;
//      - else m_* idle (wr = 0, rd = 0).
//  - m_* = selected port's fields (combinational mux). Address, data and id are don't-care when idle.
//  - pN_accept_o = m_accept_i & sel==N & req_N & !full. Zero-cycle accept pass-through.
//  - Handshake = (m_wr_o!=0 | m_rd_o) & m_accept_i.
//      - On handshake: push sel into the FIFO, last_grant <= sel, lock <= 0.
//  - If a request is presented and not accepted: lock <= 1, locked port <= sel.
//      - Grant cannot switch mid-stall; no request is ever dropped or duplicated.
//  - Responses are in issue order from the core.
//      - On m_ack_i with the FIFO non-empty: pop; pH_ack_o = 1 for head port H, other port ack = 0.
//      - pH_error_o = m_error_i. resp_id and read_data are fanned to both ports unmodified.
//      - Zero latency, combinational from m_ack_i.
//  - m_ack_i with the FIFO empty: both pN_ack_o = 0, unexpected_ack_o <= 1. Cleared only by reset.
//  - Push and pop in the same cycle: occupancy unchanged, pointers both advance. This is allowed when not full.
//      - When full, push is blocked by gating even if a pop occurs in that cycle.
//      - The freed slot becomes usable the next cycle.
//  - Pointers wrap modulo OUTSTANDING. Occupancy is held as a separate counter in 0..OUTSTANDING.
//  - Reset (async assert, sync release):
//      - FIFO empty; occupancy 0; lock 0; last_grant = 1, so port 0 wins the first contention.
//      - unexpected_ack_o = 0. All outputs 0 except the combinational mux of idle inputs.
//  - Reset mid-operation discards all tags. Late acks from the core afterwards set unexpected_ack_o.
// TESTING
//  1. p0 write addr 0x0 only, m_accept_i=1:
//     -> p0_accept_o same cycle, outstanding_o=1; m_ack_i 5 cycles later -> p0_ack_o=1, p1_ack_o=0, outstanding_o=0.
//  2. p0 and p1 reads held continuously, accept always 1:
//     -> grants alternate p0,p1,p0,p1; the acks return to ports in the same order.
//  3. p1 read with m_accept_i=0 for 3 cycles, p0 raises a request in cycle 2:
//     -> m_* stays on p1 until accepted, then p0 is granted next.
//  4. OUTSTANDING=4, 4 reads accepted with no acks:
//     -> 5th request sees accept=0 and m_rd_o=0.
//     -> One ack -> occupancy 3, then the 5th is accepted the following cycle.
//  5. m_ack_i pulse with FIFO empty:
//     -> no pN_ack_o, unexpected_ack_o=1 and it stays set until rst_n_i low.
//  6. Two requests outstanding, rst_n_i pulsed low:
//     -> outstanding_o=0 immediately, next grant goes to p0 on contention.
//  Bench: ddr3_core + ddr3_dfi_phy + ddr3 model behind m_*.
//      - Write/readback 128'hffeeddccbbaa99887766554433221100 from p0 and a distinct pattern from p1.
//      - Both must match.

Source files
------------

// File: rtl/ddr3_port_arbiter_if.sv
// Request/response bundle for one side of the ddr3 core inport.
// Masters issue requests and receive responses; the core side mirrors that.
interface ddr3_port_arbiter_if;
  logic [15:0]  wr;
  logic         rd;
  logic [31:0]  addr;
  logic [127:0] write_data;
  logic [15:0]  req_id;
  logic         accept;
  logic         ack;
  logic         error;
  logic [15:0]  resp_id;
  logic [127:0] read_data;

  modport master (
    output wr, rd, addr, write_data, req_id,
    input  accept, ack, error, resp_id, read_data
  );

  modport slave (
    input  wr, rd, addr, write_data, req_id,
    output accept, ack, error, resp_id, read_data
  );
endinterface

// File: rtl/ddr3_port_arbiter.sv
// Two-port round-robin arbiter in front of the ddr3_core inport. A tag FIFO of
// granted port indices steers the in-order responses back to their issuers.
module ddr3_port_arbiter #(
  parameter int OUTSTANDING = 4
) (
  input  logic                        clk_i,
  input  logic                        rst_n_i,
  ddr3_port_arbiter_if.slave          p0_if,
  ddr3_port_arbiter_if.slave          p1_if,
  ddr3_port_arbiter_if.master         m_if,
  output logic [$clog2(OUTSTANDING):0] outstanding_o,
  output logic                        unexpected_ack_o
);

  localparam int PTR_W = $clog2(OUTSTANDING);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    GRANT_OPEN   = 1'b0,
    GRANT_LOCKED = 1'b1
  } grant_state_e;

  grant_state_e state_q, state_d;
  logic         locked_port_q, locked_port_d;
  logic         last_grant_q, last_grant_d;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             unexpected_q, unexpected_d;
  logic             tag_q [OUTSTANDING];

  logic req0, req1, full, sel, sel_valid, present, handshake, push, pop, head;

  assign req0 = (|p0_if.wr) | p0_if.rd;
  assign req1 = (|p1_if.wr) | p1_if.rd;
  assign full = (count_q == CNT_W'(OUTSTANDING));

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_d       = state_q;
    locked_port_d = locked_port_q;
    last_grant_d  = last_grant_q;
    sel           = 1'b0;
    sel_valid     = 1'b0;

    if (state_q == GRANT_LOCKED) begin
      sel       = locked_port_q;
      sel_valid = 1'b1;
    end else if (req0 && !req1) begin
      sel       = 1'b0;
      sel_valid = 1'b1;
    end else if (req1 && !req0) begin
      sel       = 1'b1;
      sel_valid = 1'b1;
    end else if (req0 && req1) begin
      sel       = ~last_grant_q;
      sel_valid = 1'b1;
    end

    present   = sel_valid && !full && (sel ? req1 : req0);
    handshake = present && m_if.accept;

    // A stalled request pins the grant so the master never sees its request withdrawn.
    if (handshake) begin
      state_d      = GRANT_OPEN;
      last_grant_d = sel;
    end else if (present) begin
      state_d       = GRANT_LOCKED;
      locked_port_d = sel;
    end
  end

  assign m_if.wr         = present ? (sel ? p1_if.wr : p0_if.wr) : 16'h0;
  assign m_if.rd         = present && (sel ? p1_if.rd : p0_if.rd);
  assign m_if.addr       = sel ? p1_if.addr       : p0_if.addr;
  assign m_if.write_data = sel ? p1_if.write_data : p0_if.write_data;
  assign m_if.req_id     = sel ? p1_if.req_id     : p0_if.req_id;

  assign p0_if.accept = handshake && !sel;
  assign p1_if.accept = handshake &&  sel;

  assign push = handshake;
  assign pop  = m_if.ack && (count_q != '0);
  assign head = tag_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    unexpected_d = unexpected_q;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (m_if.ack && (count_q == '0)) unexpected_d = 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q       <= GRANT_OPEN;
      locked_port_q <= 1'b0;
      last_grant_q  <= 1'b1;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      unexpected_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      locked_port_q <= locked_port_d;
      last_grant_q  <= last_grant_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
      unexpected_q  <= unexpected_d;
    end
  end

  // NOTE: tag storage is not reset; an entry is only read while count_q says it holds a live tag.
  always_ff @(posedge clk_i) begin
    if (push) tag_q[wr_ptr_q] <= sel;
  end

  assign p0_if.ack       = pop && !head;
  assign p1_if.ack       = pop &&  head;
  assign p0_if.error     = p0_if.ack && m_if.error;
  assign p1_if.error     = p1_if.ack && m_if.error;
  assign p0_if.resp_id   = m_if.resp_id;
  assign p1_if.resp_id   = m_if.resp_id;
  assign p0_if.read_data = m_if.read_data;
  assign p1_if.read_data = m_if.read_data;

  assign outstanding_o    = count_q;
  assign unexpected_ack_o = unexpected_q;

endmodule
